// File: rtl/led_pattern_controller_pkg.sv
// Shared definitions for the LED pattern controller: pattern mode encodings.
package led_pattern_controller_pkg;

  localparam int unsigned MODE_W = 2;

  typedef enum logic [MODE_W-1:0] {
    MODE_COUNT   = 2'd0,
    MODE_SCAN    = 2'd1,
    MODE_BLINK   = 2'd2,
    MODE_BREATHE = 2'd3
  } mode_e;

endpackage

// File: rtl/led_pattern_controller_if.sv
// Control/status bundle between the board-level driver and the LED controller.
//   MODE_IN  : pattern select (master -> slave)
//   PAUSE_IN : freeze request (master -> slave)
//   LED_OUT  : LED drive, 1 = on (slave -> master)
//   STEP_OUT : one-cycle pulse per pattern step (slave -> master)
interface led_pattern_controller_if
  import led_pattern_controller_pkg::*;
#(
  parameter int unsigned NUM_LEDS = 3
);
  logic [MODE_W-1:0]   MODE_IN;
  logic                PAUSE_IN;
  logic [NUM_LEDS-1:0] LED_OUT;
  logic                STEP_OUT;

  modport master (output MODE_IN, output PAUSE_IN, input LED_OUT, input STEP_OUT);
  modport slave  (input MODE_IN, input PAUSE_IN, output LED_OUT, output STEP_OUT);
endinterface

// File: rtl/led_pattern_controller_prescaler.sv
// Free-running prescaler producing a step tick once per 2^PRESCALE_BITS
// unpaused cycles.
//   CLK_IN   : clock
//   RESET_N  : synchronous active-low reset
//   PAUSE_IN : hold the counter, suppress the tick
//   tick_c   : combinational tick, high while the counter is all ones
module led_prescaler #(
  parameter int unsigned PRESCALE_BITS = 23
) (
  input  logic CLK_IN,
  input  logic RESET_N,
  input  logic PAUSE_IN,
  output logic tick_c
);
  logic [PRESCALE_BITS-1:0] cnt_q;

  // Counter wraps naturally; frozen while paused.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      cnt_q <= '0;
    end else if (!PAUSE_IN) begin
      cnt_q <= cnt_q + PRESCALE_BITS'(1);
    end
  end

  assign tick_c = (cnt_q == '1) && !PAUSE_IN;
endmodule

// File: rtl/led_pattern_controller.sv
// Multi-mode LED driver: binary count, bouncing scan, blink-all, PWM breathe.
//   CLK_IN  : clock, all logic rising-edge
//   RESET_N : synchronous active-low reset
//   bus     : MODE_IN/PAUSE_IN in, registered LED_OUT/STEP_OUT out
module led_pattern_controller
  import led_pattern_controller_pkg::*;
#(
  parameter int unsigned NUM_LEDS      = 3,
  parameter int unsigned PRESCALE_BITS = 23,
  parameter int unsigned PWM_BITS      = 8
) (
  input  logic                     CLK_IN,
  input  logic                     RESET_N,
  led_pattern_controller_if.slave  bus
);
  localparam int unsigned          POS_W    = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;
  localparam logic [POS_W-1:0]     POS_MAX  = POS_W'(NUM_LEDS - 1);
  localparam logic [PWM_BITS-1:0]  DUTY_MAX = '1;

  logic                tick_c;
  mode_e               mode_in;
  mode_e               mode_q;
  logic [NUM_LEDS-1:0] count_q, count_n;
  logic [POS_W-1:0]    pos_q, pos_n;
  logic                pos_up_q, pos_up_n;
  logic                phase_q, phase_n;
  logic [PWM_BITS-1:0] duty_q, duty_n;
  logic                duty_up_q, duty_up_n;
  logic [PWM_BITS-1:0] pwm_cnt_q;
  logic [NUM_LEDS-1:0] led_q, led_n;
  logic                step_q;

  assign mode_in = mode_e'(bus.MODE_IN);

  led_prescaler #(.PRESCALE_BITS(PRESCALE_BITS)) u_prescaler (
    .CLK_IN   (CLK_IN),
    .RESET_N  (RESET_N),
    .PAUSE_IN (bus.PAUSE_IN),
    .tick_c   (tick_c)
  );

  // Next pattern state if this edge steps, and the LED image of that state.
  always_comb begin
    count_n   = count_q;
    pos_n     = pos_q;
    pos_up_n  = pos_up_q;
    phase_n   = phase_q;
    duty_n    = duty_q;
    duty_up_n = duty_up_q;
    led_n     = '0;

    if (tick_c) begin
      count_n = count_q + NUM_LEDS'(1);
      phase_n = !phase_q;

      // Bounce: the endpoint is shown once, the turn happens on the step away.
      if (NUM_LEDS == 1) begin
        pos_n    = '0;
        pos_up_n = 1'b1;
      end else if (pos_up_q) begin
        if (pos_q == POS_MAX) begin
          pos_n    = pos_q - POS_W'(1);
          pos_up_n = 1'b0;
        end else begin
          pos_n = pos_q + POS_W'(1);
        end
      end else if (pos_q == '0) begin
        pos_n    = pos_q + POS_W'(1);
        pos_up_n = 1'b1;
      end else begin
        pos_n = pos_q - POS_W'(1);
      end

      if (duty_up_q) begin
        if (duty_q == DUTY_MAX) begin
          duty_n    = duty_q - PWM_BITS'(1);
          duty_up_n = 1'b0;
        end else begin
          duty_n = duty_q + PWM_BITS'(1);
        end
      end else if (duty_q == '0) begin
        duty_n    = duty_q + PWM_BITS'(1);
        duty_up_n = 1'b1;
      end else begin
        duty_n = duty_q - PWM_BITS'(1);
      end
    end

    case (mode_q)
      MODE_COUNT:   led_n = count_n;
      MODE_SCAN:    led_n = NUM_LEDS'(1) << pos_n;
      MODE_BLINK:   led_n = {NUM_LEDS{phase_n}};
      MODE_BREATHE: led_n = {NUM_LEDS{pwm_cnt_q < duty_n}};
      default:      led_n = '0;
    endcase
  end

  // Pattern FSM: mode change restarts the pattern, pause freezes it.
  always_ff @(posedge CLK_IN) begin
    if (!RESET_N) begin
      mode_q    <= MODE_COUNT;
      count_q   <= '0;
      pos_q     <= '0;
      pos_up_q  <= 1'b1;
      phase_q   <= 1'b0;
      duty_q    <= '0;
      duty_up_q <= 1'b1;
      pwm_cnt_q <= '0;
      led_q     <= '0;
      step_q    <= 1'b0;
    end else begin
      mode_q <= mode_in;
      if (mode_in != mode_q) begin
        count_q   <= '0;
        pos_q     <= '0;
        pos_up_q  <= 1'b1;
        phase_q   <= 1'b0;
        duty_q    <= '0;
        duty_up_q <= 1'b1;
        pwm_cnt_q <= '0;
        led_q     <= (mode_in == MODE_SCAN) ? NUM_LEDS'(1) : '0;
        step_q    <= 1'b0;
      end else if (bus.PAUSE_IN) begin
        step_q <= 1'b0;
      end else begin
        count_q   <= count_n;
        pos_q     <= pos_n;
        pos_up_q  <= pos_up_n;
        phase_q   <= phase_n;
        duty_q    <= duty_n;
        duty_up_q <= duty_up_n;
        pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
        led_q     <= led_n;
        step_q    <= tick_c;
      end
    end
  end

  assign bus.LED_OUT  = led_q;
  assign bus.STEP_OUT = step_q;
endmodule

// File: tb/tb_led_pattern_controller.sv
// Randomised scoreboard bench for led_pattern_controller (3 LEDs, 4-cycle tick,
// 3-bit PWM). The reference model tracks a step index and derives each
// pattern arithmetically from it.
module tb_led_pattern_controller;
  localparam int unsigned NL = 3;
  localparam int unsigned PB = 2;
  localparam int unsigned PW = 3;

  typedef struct {
    logic [NL-1:0] led;
    logic          step;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;

  led_pattern_controller_if #(.NUM_LEDS(NL)) bus ();

  led_pattern_controller #(
    .NUM_LEDS      (NL),
    .PRESCALE_BITS (PB),
    .PWM_BITS      (PW)
  ) dut (
    .CLK_IN  (clk),
    .RESET_N (rst_n),
    .bus     (bus)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  // Reference model state
  int            m_presc = 0;
  int            m_mode  = 0;
  int            m_k     = 0;   // steps taken since the pattern restarted
  int            m_pwm   = 0;
  logic [NL-1:0] m_led   = '0;
  logic          m_step  = 1'b0;

  localparam int unsigned TICK_PERIOD = 1 << PB;
  localparam int unsigned PWM_PERIOD  = 1 << PW;
  localparam int unsigned DUTY_MAX    = PWM_PERIOD - 1;

  // LED image after k steps; pwm is the PWM count before the current edge.
  function automatic logic [NL-1:0] pattern(input int mode, input int k, input int pwm);
    int p, pos, duty;
    case (mode)
      0: return NL'(k % (1 << NL));
      1: begin
        p   = k % (2 * (NL - 1));
        pos = (p < NL) ? p : 2 * (NL - 1) - p;
        return NL'(1 << pos);
      end
      2: return (k % 2 == 1) ? '1 : '0;
      default: begin
        p    = k % (2 * DUTY_MAX);
        duty = (p <= DUTY_MAX) ? p : 2 * DUTY_MAX - p;
        return (pwm < duty) ? '1 : '0;
      end
    endcase
  endfunction

  task automatic model_edge(input logic r, input int mode, input logic pause);
    bit   tick;
    int   pwm_old;
    exp_t e;
    if (!r) begin
      m_presc = 0; m_mode = 0; m_k = 0; m_pwm = 0; m_led = '0; m_step = 1'b0;
    end else begin
      tick = (m_presc == TICK_PERIOD - 1) && !pause;
      if (!pause) m_presc = (m_presc + 1) % TICK_PERIOD;
      if (mode != m_mode) begin
        m_k = 0; m_pwm = 0; m_step = 1'b0;
        m_led = (mode == 1) ? NL'(1) : '0;
      end else if (pause) begin
        m_step = 1'b0;
      end else begin
        m_step = tick;
        if (tick) m_k++;
        pwm_old = m_pwm;
        m_pwm   = (m_pwm + 1) % PWM_PERIOD;
        m_led   = pattern(m_mode, m_k, pwm_old);
      end
      m_mode = mode;
    end
    e.led  = m_led;
    e.step = m_step;
    exp_q.push_back(e);
  endtask

  // Drive one input setting for n cycles, modelling each rising edge.
  task automatic drive(input logic r, input int mode, input logic pause, input int n);
    for (int i = 0; i < n; i++) begin
      rst_n        = r;
      bus.MODE_IN  = 2'(mode);
      bus.PAUSE_IN = pause;
      @(posedge clk);
      model_edge(r, mode, pause);
      @(negedge clk);
    end
  endtask

  // Monitor: outputs are presented every cycle; compare mid-cycle.
  initial begin
    exp_t e;
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL scoreboard_empty t=%0t", $time);
      end else begin
        e = exp_q.pop_front();
        n_checks++;
        if (bus.LED_OUT === e.led) n_pass++;
        else $display("FAIL led_out t=%0t got %b exp %b", $time, bus.LED_OUT, e.led);
        n_checks++;
        if (bus.STEP_OUT === e.step) n_pass++;
        else $display("FAIL step_out t=%0t got %b exp %b", $time, bus.STEP_OUT, e.step);
      end
    end
  end

  initial begin
    int   mode;
    logic pause;
    logic r;
    // Reset, run count, reset mid-run, count long enough to wrap
    drive(1'b0, 0, 1'b0, 3);
    drive(1'b1, 0, 1'b0, 22);
    drive(1'b0, 0, 1'b0, 1);
    drive(1'b1, 0, 1'b0, 40);
    // Scan, blink with a pause between ticks, breathe over full periods
    drive(1'b1, 1, 1'b0, 30);
    drive(1'b1, 2, 1'b0, 6);
    drive(1'b1, 2, 1'b1, 10);
    drive(1'b1, 2, 1'b0, 12);
    drive(1'b1, 3, 1'b0, 130);
    drive(1'b1, 0, 1'b0, 7);
    drive(1'b1, 1, 1'b0, 9);

    // Random run: sticky modes, sporadic pauses, rare resets
    mode = 3;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 99) == 0) mode = int'($urandom_range(0, 3));
      pause = ($urandom_range(0, 7) == 0);
      r     = ($urandom_range(0, 599) != 0);
      drive(r, mode, pause, 1);
    end

    #2;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
